// File: rtl/riscalu_pkg.sv
// riscalu_pkg: opcode encoding and helpers shared by the registered accumulator ALU
package riscalu_pkg;
  typedef logic [2:0] opcode_t;
  localparam opcode_t OP_PASSA = 3'b000;
  localparam opcode_t OP_LDA   = 3'b001;
  localparam opcode_t OP_ADD   = 3'b010;
  localparam opcode_t OP_AND   = 3'b011;
  localparam opcode_t OP_XOR   = 3'b100;
  localparam opcode_t OP_PASSD = 3'b101;
  localparam opcode_t OP_SUB   = 3'b110;
  localparam opcode_t OP_ADDC  = 3'b111;
  function automatic logic writes_acc(opcode_t op);
    return !(op == OP_PASSA || op == OP_PASSD);
  endfunction
endpackage

// File: rtl/riscalu_core.sv
// riscalu_core: combinational datapath producing result, next carry/overflow and accumulator write enable
module riscalu_core import riscalu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit SATURATE = 1'b0
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] a,
  input  logic             c,
  output logic [WIDTH-1:0] r,
  output logic             carry_n,
  output logic             ovf_n,
  output logic             acc_we
);
  logic [WIDTH:0] sum, diff;
  logic is_add, is_sub, add_ovf, sub_ovf;
  assign is_add  = opcode == OP_ADD || opcode == OP_ADDC;
  assign is_sub  = opcode == OP_SUB;
  assign sum     = {1'b0, d} + {1'b0, a} + {{WIDTH{1'b0}}, opcode == OP_ADDC && c};
  assign diff    = {1'b0, a} - {1'b0, d};
  assign add_ovf = (a[WIDTH-1] == d[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != d[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign carry_n = is_add ? sum[WIDTH] : is_sub ? diff[WIDTH] : c;
  assign ovf_n   = is_add ? add_ovf : is_sub ? sub_ovf : 1'b0;
  assign acc_we  = writes_acc(opcode);
  always_comb begin
    r = 'x;
    case (opcode)
      OP_PASSA:         r = a;
      OP_LDA, OP_PASSD: r = d;
      OP_ADD, OP_ADDC:  r = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      OP_AND:           r = d & a;
      OP_XOR:           r = d ^ a;
      OP_SUB:           r = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default:          r = 'x;
    endcase
  end
endmodule

// File: rtl/riscalu_pipe.sv
// riscalu_pipe: accumulator ALU with registered result, flags and valid/ready handshake
module riscalu_pipe import riscalu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] accum
);
  logic [WIDTH-1:0] r, acc_next;
  logic carry_n, ovf_n, acc_we, accept;
  riscalu_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
    .opcode(opcode), .d(data), .a(accum), .c(carry),
    .r(r), .carry_n(carry_n), .ovf_n(ovf_n), .acc_we(acc_we)
  );
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_next = acc_we ? r : accum;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      accum     <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_out   <= r;
      accum     <= acc_next;
      zero      <= acc_next == '0;
      carry     <= carry_n;
      overflow  <= ovf_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
